// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the scrolling 7-segment driver.
//   state_e    - controller state (BLANK / RUN / HOLD)
//   SEG_CODE   - active-high a..g,dp pattern per hex nibble (bit7 = a, bit0 = dp)
//   SEG_BLANK  - active-low "all segments off" pattern
//   idx_width  - index width for a count of n items, never less than 1
package seg_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_CODE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble - 4-bit hex value
//   seg    - active-low pattern, bit7..bit1 = a..g, bit0 = dp (dp always off)
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = ~SEG_CODE[nibble];

endmodule

// File: rtl/seg_scroll.sv
// seg_scroll: scrolling hex display driver for a bank of active-low
// 7-segment displays. Shows a NUM_DIGITS-wide window of a NUM_CHARS
// nibble buffer, rotated at a prescaled rate (RUN) or stepped by hand (HOLD).
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_en      - 1 = auto-scroll, 0 = hold
//   i_dir     - 0 = offset increments, 1 = offset decrements
//   i_load    - pulse: latch i_data, restart window and prescaler
//   i_data    - buffer contents, char j = i_data[4j+3:4j]
//   i_step    - pulse: advance one position while holding
//   o_seg     - digit k = o_seg[8k+7:8k], active-low, registered
//   o_offset  - current window start index
//   o_tick    - one-cycle pulse in the cycle the offset changes
//
// Build option: define SEG_SCROLL_BLINK_EN to blink the display in HOLD
// (blank every other CLK_DIV-cycle period). Undefined: steady display.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_BLANK | display dark after reset, waits for the first load
// ST_RUN   | window advances once every CLK_DIV cycles
// ST_HOLD  | window frozen, i_step advances it by one
module seg_scroll
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_CHARS  = 8,
  parameter int CLK_DIV    = 5000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_en,
  input  logic                              i_dir,
  input  logic                              i_load,
  input  logic [4*NUM_CHARS-1:0]            i_data,
  input  logic                              i_step,
  output logic [8*NUM_DIGITS-1:0]           o_seg,
  output logic [idx_width(NUM_CHARS)-1:0]   o_offset,
  output logic                              o_tick
);

  localparam int OW = idx_width(NUM_CHARS);
  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = idx_width(NUM_CHARS + NUM_DIGITS);
  localparam int BW = idx_width(4 * NUM_CHARS);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);
  localparam logic [OW-1:0] LAST   = OW'(NUM_CHARS - 1);

  state_e                   state_q, state_d;
  logic [PW-1:0]            presc_q;
  logic [OW-1:0]            offset_q, off_nxt;
  logic [4*NUM_CHARS-1:0]   buf_q;
  logic [8*NUM_DIGITS-1:0]  seg_q, seg_dec;
  logic                     tick_q;
  logic                     active, run, hold, adv, blank_now;
  logic [OW:0]              inc_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (i_load) state_d = i_en ? ST_RUN : ST_HOLD;
      ST_RUN:   if (!i_en)  state_d = ST_HOLD;
      ST_HOLD:  if (i_en)   state_d = ST_RUN;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Counting/stepping follow i_en in the same cycle it changes, so the
  // prescaler freezes exactly where i_en drops and resumes with no dead cycle.
  assign active = (state_q != ST_BLANK);
  assign run    = active && i_en;
  assign hold   = active && !i_en;
  assign adv    = !i_load && ((run && (presc_q == PRE_TC)) || (hold && i_step));

  // Wrap by explicit compare: NUM_CHARS need not be a power of two.
  assign inc_w = {1'b0, offset_q} + (OW+1)'(1);

  always_comb begin
    off_nxt = offset_q;
    if (i_dir)
      off_nxt = (offset_q == '0) ? LAST : offset_q - OW'(1);
    else
      off_nxt = (inc_w == (OW+1)'(NUM_CHARS)) ? '0 : inc_w[OW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BLANK;
      presc_q  <= '0;
      offset_q <= '0;
      buf_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= adv;
      if (i_load) begin
        buf_q    <= i_data;
        offset_q <= '0;
        presc_q  <= '0;
      end else begin
        if (run)
          presc_q <= (presc_q == PRE_TC) ? '0 : presc_q + PW'(1);
        if (adv)
          offset_q <= off_nxt;
      end
    end
  end

  // Digit k shows char (offset + k) mod NUM_CHARS; chars repeat when the
  // window is wider than the buffer.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [SW-1:0] sum;
    logic [SW-1:0] idx;
    logic [BW-1:0] base;
    assign sum  = SW'(offset_q) + SW'(k);
    assign idx  = sum % SW'(NUM_CHARS);
    assign base = BW'({idx, 2'b00});
    seg_hex_dec u_dec (
      .nibble (buf_q[base +: 4]),
      .seg    (seg_dec[8*k +: 8])
    );
  end

`ifdef SEG_SCROLL_BLINK_EN
  logic [PW-1:0] blink_cnt_q;
  logic          blink_q;

  // Phase restarts on every entry to HOLD so each hold opens with the
  // display visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_q == ST_HOLD) begin
      if (blink_cnt_q == PRE_TC) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + PW'(1);
      end
    end
  end

  assign blank_now = (state_q == ST_BLANK) || ((state_q == ST_HOLD) && blink_q);
`else
  assign blank_now = (state_q == ST_BLANK);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
    else
      seg_q <= blank_now ? {NUM_DIGITS{SEG_BLANK}} : seg_dec;
  end

  assign o_seg    = seg_q;
  assign o_offset = offset_q;
  assign o_tick   = tick_q;

endmodule

// File: tb/tb_seg_scroll.sv
// tb_seg_scroll: directed bench for seg_scroll (CLK_DIV = 4). Two instances
// share stimulus: an 8-char buffer and a 5-char buffer, both 8 digits wide.
module tb_seg_scroll;

  localparam logic [63:0] ALL1 = {64{1'b1}};
  localparam logic [31:0] DA   = 32'h76543210;
  localparam logic [31:0] DB   = 32'hFEDCBA98;

  // Active-low patterns, hand-inverted from the active-high decode table.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_dir, i_load, i_step;
  logic [31:0] i_data;
  logic [19:0] i_data5;
  logic [63:0] o_seg, o_seg5;
  logic [2:0]  o_offset, o_offset5;
  logic        o_tick, o_tick5;

  int total = 0;
  int bad   = 0;

  assign i_data5 = i_data[19:0];

  always #5 clk = ~clk;

  seg_scroll #(.NUM_DIGITS(8), .NUM_CHARS(8), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_dir(i_dir), .i_load(i_load),
    .i_data(i_data), .i_step(i_step), .o_seg(o_seg), .o_offset(o_offset),
    .o_tick(o_tick)
  );

  seg_scroll #(.NUM_DIGITS(8), .NUM_CHARS(5), .CLK_DIV(4)) dut5 (
    .clk(clk), .rst(rst), .i_en(i_en), .i_dir(i_dir), .i_load(i_load),
    .i_data(i_data5), .i_step(i_step), .o_seg(o_seg5), .o_offset(o_offset5),
    .o_tick(o_tick5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_disp(input logic [31:0] d, input int nc, input int off);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      idx = (off + k) % nc;
      r[8*k +: 8] = SEG_LUT[d[4*idx +: 4]];
    end
    return r;
  endfunction

  // Load d and run ncyc cycles in RUN, checking tick cadence, offset and
  // display on both instances every cycle.
  task automatic run_seq(input logic [31:0] d, input logic d1, input int ncyc,
                         input logic from_blank);
    int m, eo, eo5, prev, prev5;
    i_dir = d1; i_en = 1'b1; i_data = d; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    chk("ld_tick", o_tick, 0);
    chk("ld_off", o_offset, 0);
    if (from_blank) chk("ld_seg_dark", o_seg, ALL1);
    prev = 0; prev5 = 0;
    for (int n = 1; n <= ncyc; n++) begin
      cyc();
      m   = n / 4;
      eo  = d1 ? (8 - m % 8) % 8 : m % 8;
      eo5 = d1 ? (5 - m % 5) % 5 : m % 5;
      chk("seq_tick",  o_tick, (n % 4 == 0));
      chk("seq_off",   o_offset, eo);
      chk("seq_seg",   o_seg, exp_disp(d, 8, prev));
      chk("seq_tick5", o_tick5, (n % 4 == 0));
      chk("seq_off5",  o_offset5, eo5);
      chk("seq_seg5",  o_seg5, exp_disp(d, 5, prev5));
      if (n == 1) begin
        chk("d0_first",  o_seg[7:0],    SEG_LUT[d[3:0]]);
        chk("d1_first",  o_seg[15:8],   SEG_LUT[d[7:4]]);
        chk("n5_digit5", o_seg5[47:40], SEG_LUT[d[3:0]]);
        chk("n5_digit7", o_seg5[63:56], SEG_LUT[d[11:8]]);
      end
      if (d1 && n == 5) begin
        chk("dir1_d0",  o_seg[7:0],  SEG_LUT[d[31:28]]);
        chk("dir1_d0_5", o_seg5[7:0], SEG_LUT[d[19:16]]);
      end
      prev = eo; prev5 = eo5;
    end
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_dir = 1'b0; i_load = 1'b0; i_step = 1'b0;
    i_data = '0;
    repeat (2) cyc();
    chk("rst_seg",  o_seg, ALL1);
    chk("rst_off",  o_offset, 0);
    chk("rst_tick", o_tick, 0);
    rst = 1'b0;
    cyc();
    chk("blank_seg", o_seg, ALL1);

    // Auto-scroll left through a full wrap, then right.
    run_seq(DA, 1'b0, 33, 1'b1);
    run_seq(DA, 1'b1, 9, 1'b0);

    // Hold at prescaler = 2, manual step, resume without restarting prescaler.
    i_dir = 1'b0; i_en = 1'b1; i_data = DB; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    cyc(); cyc();
    chk("pre_hold_tick", o_tick, 0);
    i_en = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      chk("hold_tick", o_tick, 0);
      chk("hold_off", o_offset, 0);
`ifdef SEG_SCROLL_BLINK_EN
      if (n <= 17)
        chk("blink_seg", o_seg,
            (n >= 2 && ((n - 2) / 4) % 2 == 1) ? ALL1 : exp_disp(DB, 8, 0));
`else
      chk("hold_seg", o_seg, exp_disp(DB, 8, 0));
`endif
    end
    i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    chk("step_tick", o_tick, 1);
    chk("step_off", o_offset, 1);
    cyc();
    chk("step_tick_end", o_tick, 0);
`ifndef SEG_SCROLL_BLINK_EN
    chk("step_seg", o_seg, exp_disp(DB, 8, 1));
`endif
    i_en = 1'b1;
    cyc();
    chk("resume_a_tick", o_tick, 0);
    chk("resume_a_off", o_offset, 1);
    cyc();
    chk("resume_b_tick", o_tick, 1);
    chk("resume_b_off", o_offset, 2);
    for (int n = 1; n <= 3; n++) begin
      cyc();
      chk("run_steady_seg", o_seg, exp_disp(DB, 8, 2));
      chk("run_steady_tick", o_tick, 0);
    end

    // Step ignored in RUN; load coincident with a tick wins.
    i_dir = 1'b0; i_en = 1'b1; i_data = DA; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    chk("run_step_off", o_offset, 0);
    chk("run_step_tick", o_tick, 0);
    repeat (6) cyc();
    chk("pre_coinc_off", o_offset, 1);
    i_data = DB; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    chk("coinc_off", o_offset, 0);
    chk("coinc_tick", o_tick, 0);
    chk("coinc_off5", o_offset5, 0);
    cyc();
    chk("coinc_seg", o_seg, exp_disp(DB, 8, 0));
    chk("coinc_d0", o_seg[7:0], 8'h01);
    cyc(); cyc(); cyc();
    chk("post_coinc_tick", o_tick, 1);
    chk("post_coinc_off", o_offset, 1);

    // Asynchronous reset mid-RUN, then BLANK ignores step and enable.
    cyc();
    #3 rst = 1'b1;
    #1;
    chk("arst_seg", o_seg, ALL1);
    chk("arst_off", o_offset, 0);
    chk("arst_tick", o_tick, 0);
    chk("arst_seg5", o_seg5, ALL1);
    cyc();
    rst = 1'b0; i_en = 1'b0; i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    chk("blank_step_off", o_offset, 0);
    chk("blank_step_tick", o_tick, 0);
    chk("blank_step_seg", o_seg, ALL1);
    i_en = 1'b1;
    repeat (3) cyc();
    chk("blank_en_seg", o_seg, ALL1);
    chk("blank_en_tick", o_tick, 0);
    chk("blank_en_off", o_offset, 0);
    i_en = 1'b0; i_data = DA; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    chk("ld_hold_off", o_offset, 0);
    chk("ld_hold_tick", o_tick, 0);
    i_step = 1'b1;
    cyc();
    i_step = 1'b0;
    chk("hold2_step_tick", o_tick, 1);
    chk("hold2_step_off", o_offset, 1);
    cyc();
    chk("hold2_seg", o_seg, exp_disp(DA, 8, 1));
    chk("hold2_tick_end", o_tick, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scroll.md
Name: seg_scroll

Overview:
Parametrised scrolling hex display driver for the board's 7-segment bank.
- Holds a loadable buffer of NUM_CHARS hex nibbles and shows a NUM_DIGITS-wide window of it, one digit per display.
- Rotates the window left or right at a prescaled rate, or steps it manually while held.
- Sits between top-level switch/button logic and the board's active-low segment pins.

Parameters:
NUM_DIGITS, 8, number of physical 7-segment displays driven (1..16)
NUM_CHARS, 8, number of hex characters in the scroll buffer (1..32, need not be a power of 2)
CLK_DIV, 5000000, clk cycles per scroll step (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_en  input  1  1 = auto-scroll (RUN), 0 = hold (HOLD)
i_dir  input  1  0 = offset increments (text moves left), 1 = offset decrements
i_load  input  1  single-cycle pulse: latch i_data into buffer
i_data  input  4*NUM_CHARS  buffer contents; char j = i_data[4j+3:4j]
i_step  input  1  single-cycle pulse: advance one position while in HOLD
o_seg  output  8*NUM_DIGITS  digit k = o_seg[8k+7:8k]; bit7..bit1 = a..g, bit0 = dp; active-low
o_offset  output  $clog2(NUM_CHARS) (min 1)  current window start index
o_tick  output  1  one-cycle pulse on each position change

Behaviour:
- Reset (async assert): state = BLANK, prescaler = 0, offset = 0, buffer = 0, o_seg = all 1s, o_tick = 0.
- States:
  - BLANK: display dark, ignores i_en/i_step; i_load -> RUN if i_en else HOLD.
  - RUN: i_en=0 -> HOLD.
  - HOLD: i_en=1 -> RUN.
- Prescaler: counts 0..CLK_DIV-1 only in RUN; held (not cleared) in HOLD; cleared on i_load.
- Tick in RUN when prescaler == CLK_DIV-1; offset updates on the following edge.
- i_step in HOLD advances offset on the next edge; i_step in RUN/BLANK is ignored.
- Advance:
  - dir=0: offset = (offset+1 == NUM_CHARS) ? 0 : offset+1.
  - dir=1: offset = (offset == 0) ? NUM_CHARS-1 : offset-1.
  - Explicit compare is required; no power-of-2 wrap is assumed.
- o_tick = 1 in the cycle the offset register changes.
- i_load: buffer <= i_data, offset <= 0, prescaler <= 0, no o_tick.
- Priority within a cycle: rst > i_load > tick/step.
- Digit k shows buffer char (offset+k) mod NUM_CHARS. The modulo applies repeatedly if NUM_DIGITS > NUM_CHARS, so characters repeat.
- Hex decode (active-high a..g,dp before inversion):
  - 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0
  - 8:FE 9:F6 A:EE b:3E C:9C d:7A E:9E F:8E
  - dp = 0 for all characters.
- o_seg = bitwise inverse of the decode, registered.
- Latency: o_seg reflects new offset/buffer 1 cycle after the register update (2 edges after tick/load).
- In BLANK, o_seg = all 1s.

Optional Feature:
Macro: SEG_SCROLL_BLINK_EN.
- Defined: in HOLD, display blinks.
  - A second counter toggles a phase every CLK_DIV cycles.
  - Phase 1 forces o_seg to all 1s. Phase resets to 0 on entering HOLD.
  - RUN is unaffected.
- Undefined: HOLD shows a steady display; no blink counter is synthesised.

Decomposition:
- Package seg_pkg holds:
  - state enum (BLANK, RUN, HOLD)
  - 16-entry segment encoding constant array
  - SEG_BLANK = 8'hFF
- One sub-module, seg_hex_dec: combinational 4-bit nibble -> 8-bit active-low pattern, instantiated NUM_DIGITS times via generate.

Test Plan:
- CLK_DIV=4, defaults: after rst, o_seg = all 1s; load i_data=32'h76543210, i_en=1 -> 2 cycles later digit0 = 8'h03 (0), digit1 = 8'h9F (1); o_tick every 4 cycles; offset 0,1,..7,0.
- i_dir=1 after load -> offset 0 -> 7 -> 6; digit0 shows 7 = 8'h1F after first tick.
- NUM_CHARS=5, NUM_DIGITS=8: offset sequence 0..4,0; digit5 shows char 0, digit7 shows char 2.
- i_en=0 mid-count at prescaler=2: no tick for 100 cycles. One i_step -> offset+1 with o_tick. i_en=1 -> next tick after 1 more cycle (prescaler resumed at 2, not restarted).
- i_load coincident with tick: offset = 0, no o_tick, buffer updated. rst asserted asynchronously mid-RUN -> o_seg all 1s immediately, i_step ignored until load.
- With SEG_SCROLL_BLINK_EN, CLK_DIV=4: in HOLD, o_seg alternates digits / all 1s every 4 cycles; returning to RUN shows a steady display.
